// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data RAM between two bus masters.
// Latency: gnt 1 cycle after req is sampled, read data 2 cycles; occupancy 2 (write) / 3 (read).
// Backpressure: req held until gnt; requests are only sampled in IDLE, so they wait out ACCESS/RESP.
module dmem_arbiter #(
  parameter int ADDR_SIZE = 32,
  parameter int RAM_DEPTH = 1024,
  localparam int AW = $clog2(RAM_DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 m0_req,
  input  logic                 m0_d_rw,
  input  logic [ADDR_SIZE-1:0] m0_daddr,
  input  logic [ADDR_SIZE-1:0] m0_ddata_w,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic                 m0_err,
  input  logic                 m1_req,
  input  logic                 m1_d_rw,
  input  logic [ADDR_SIZE-1:0] m1_daddr,
  input  logic [ADDR_SIZE-1:0] m1_ddata_w,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic                 m1_err,
  output logic [ADDR_SIZE-1:0] ddata_r,
  output logic [AW-1:0]        ram_address,
  output logic [ADDR_SIZE-1:0] ram_data,
  output logic                 ram_wren,
  output logic                 ram_wread,
  input  logic [ADDR_SIZE-1:0] ram_q
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               state;
  logic                 last_grant;
  logic                 cmd_id;
  logic                 cmd_rw;
  logic                 cmd_ok;
  logic [AW-1:0]        cmd_word;
  logic [ADDR_SIZE-1:0] cmd_wdata;
  logic [1:0]           gnt_q;
  logic [1:0]           err_q;
  logic [1:0]           rvalid_q;
  logic                 wren_q;
  logic                 wread_q;

  logic                 win;
  logic                 win_rw;
  logic                 win_ok;
  logic [ADDR_SIZE-1:0] win_addr;
  logic [ADDR_SIZE-1:0] win_wdata;

  // On a tie the master that did not win last time goes next.
  always_comb begin
    win       = (m0_req && m1_req) ? ~last_grant : m1_req;
    win_rw    = win ? m1_d_rw    : m0_d_rw;
    win_addr  = win ? m1_daddr   : m0_daddr;
    win_wdata = win ? m1_ddata_w : m0_ddata_w;
    win_ok    = (win_addr[ADDR_SIZE-1:AW+2] == '0) && (win_addr[1:0] == 2'b00);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cmd_id     <= 1'b0;
      cmd_rw     <= 1'b0;
      cmd_ok     <= 1'b0;
      cmd_word   <= '0;
      cmd_wdata  <= '0;
      gnt_q      <= '0;
      err_q      <= '0;
      rvalid_q   <= '0;
      wren_q     <= 1'b0;
      wread_q    <= 1'b0;
    end else begin
      gnt_q    <= '0;
      err_q    <= '0;
      rvalid_q <= '0;
      wren_q   <= 1'b0;
      wread_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            cmd_id        <= win;
            cmd_rw        <= win_rw;
            cmd_ok        <= win_ok;
            cmd_word      <= win_addr[AW+1:2];
            cmd_wdata     <= win_wdata;
            last_grant    <= win;
            gnt_q[win]    <= 1'b1;
            err_q[win]    <= ~win_ok;
            wren_q        <= win_ok & ~win_rw;
            wread_q       <= win_ok & win_rw;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          // Rejected reads still get a response cycle so the master is never left waiting.
          if (cmd_rw) begin
            rvalid_q[cmd_id] <= 1'b1;
            state            <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m0_gnt      = gnt_q[0];
  assign m1_gnt      = gnt_q[1];
  assign m0_err      = err_q[0];
  assign m1_err      = err_q[1];
  assign m0_rvalid   = rvalid_q[0];
  assign m1_rvalid   = rvalid_q[1];
  assign ram_address = cmd_word;
  assign ram_data    = cmd_wdata;
  // Enables are masked by reset so a reset landing on ACCESS cannot corrupt RAM.
  assign ram_wren    = wren_q & ~RESET;
  assign ram_wread   = wread_q & ~RESET;
  assign ddata_r     = (state == RESP && cmd_ok) ? ram_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural RAM, scoreboard of expected grants and read responses.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        m0_req = 0, m0_d_rw = 0, m1_req = 0, m1_d_rw = 0;
  logic [31:0] m0_daddr = 0, m0_ddata_w = 0, m1_daddr = 0, m1_ddata_w = 0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] ddata_r, ram_data;
  logic [31:0] ram_q = 0;
  logic [9:0]  ram_address;
  logic        ram_wren, ram_wread;

  typedef struct {
    bit          m;
    bit          rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  vec_t        gq[$];
  vec_t        rq[$];
  vec_t        tbl[12];
  vec_t        me;
  logic [31:0] mem[1024];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  dmem_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .m0_req(m0_req), .m0_d_rw(m0_d_rw), .m0_daddr(m0_daddr), .m0_ddata_w(m0_ddata_w),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err),
    .m1_req(m1_req), .m1_d_rw(m1_d_rw), .m1_daddr(m1_daddr), .m1_ddata_w(m1_ddata_w),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err),
    .ddata_r(ddata_r), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_wread(ram_wread), .ram_q(ram_q)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (ram_wren)  mem[ram_address] <= ram_data;
    if (ram_wread) ram_q <= mem[ram_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit m, input bit req, input bit rw, input logic [31:0] a,
                       input logic [31:0] d);
    if (m) begin m1_req = req; m1_d_rw = rw; m1_daddr = a; m1_ddata_w = d; end
    else   begin m0_req = req; m0_d_rw = rw; m0_daddr = a; m0_ddata_w = d; end
  endtask

  // Waits (bounded) for a gnt (rv=0) or rvalid (rv=1) pulse, sampled on the falling edge.
  task automatic wait_ev(input bit rv, input int maxc, output bit f, output int c, output bit id);
    int n = 0;
    f = 0; c = 0; id = 0;
    while (!f && n < maxc) begin
      @(negedge CLK);
      n++;
      if (rv ? (m0_rvalid || m1_rvalid) : (m0_gnt || m1_gnt)) begin
        f = 1; c = cyc; id = rv ? m1_rvalid : m1_gnt;
      end
    end
  endtask

  // Called just after a rising edge with the arbiter idle.
  task automatic do_cmd(input vec_t v);
    int c0, c;
    bit f, id;
    c0 = cyc;
    drive(v.m, 1, v.rw, v.addr, v.wdata);
    gq.push_back(v);
    wait_ev(0, 8, f, c, id);
    if (!f) chk("gnt_timeout", 0, 1);
    else    chk("gnt_latency", c - c0, 1);
    @(posedge CLK); #1;
    drive(v.m, 0, v.rw, v.addr, v.wdata);
    if (v.rw) begin
      wait_ev(1, 8, f, c, id);
      if (!f) chk("rvalid_timeout", 0, 1);
      else    chk("rd_latency", c - c0, 2);
    end
  endtask

  // Scoreboard monitor: every gnt/rvalid must match the next expected entry.
  always @(negedge CLK) begin
    if (m0_gnt || m1_gnt) begin
      chk("gnt_onehot", {31'b0, m0_gnt & m1_gnt}, 0);
      if (gq.size() == 0) chk("gnt_unexpected", 1, 0);
      else begin
        me = gq.pop_front();
        chk("gnt_id", {31'b0, m1_gnt}, {31'b0, me.m});
        chk("err", {31'b0, me.m ? m1_err : m0_err}, {31'b0, me.err});
        chk("err_other", {31'b0, me.m ? m0_err : m1_err}, 0);
        chk("ram_wren", {31'b0, ram_wren}, {31'b0, !me.rw && !me.err});
        chk("ram_wread", {31'b0, ram_wread}, {31'b0, me.rw && !me.err});
        if (!me.err) chk("ram_address", {22'b0, ram_address}, {22'b0, me.addr[11:2]});
        if (!me.rw && !me.err) chk("ram_data", ram_data, me.wdata);
        if (me.rw) rq.push_back(me);
      end
    end else begin
      chk("idle_strobes", {28'b0, ram_wren, ram_wread, m0_err, m1_err}, 0);
    end
    if (m0_rvalid || m1_rvalid) begin
      chk("rvalid_onehot", {31'b0, m0_rvalid & m1_rvalid}, 0);
      if (rq.size() == 0) chk("rvalid_unexpected", 1, 0);
      else begin
        me = rq.pop_front();
        chk("rvalid_id", {31'b0, m1_rvalid}, {31'b0, me.m});
        chk("ddata_r", ddata_r, me.rdata);
      end
    end else begin
      chk("ddata_r_idle", ddata_r, 0);
    end
  end

  initial begin
    int  c, cprev;
    bit  f, id;
    vec_t v;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    //           m     rw    addr           wdata          err   rdata
    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0,        1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0006, 32'h5555AAAA, 1'b1, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0000_0FFC, 32'hA5A5A5A5, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 32'h0000_0FFC, 32'h0,        1'b0, 32'hA5A5A5A5};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,        1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 32'h8000_0010, 32'h0,        1'b1, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0000_0004, 32'h11223344, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 32'h0000_0004, 32'h0,        1'b0, 32'h11223344};
    tbl[10] = '{1'b0, 1'b1, 32'h0000_0013, 32'h0,        1'b1, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 32'h0000_0020, 32'hCAFEF00D, 1'b0, 32'h0};

    // Reset held for two cycles: every strobe and the read bus must be quiet.
    repeat (2) begin
      @(negedge CLK);
      chk("rst_outs", {24'b0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err,
                       ram_wren, ram_wread}, 0);
      chk("rst_ddata_r", ddata_r, 0);
    end
    @(posedge CLK); #1;
    RESET = 0;

    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      do_cmd(tbl[i]);
    end

    // Sustained contention straight out of reset: m0, m1, m0, m1 at 3-cycle spacing.
    @(posedge CLK); #1;
    RESET = 1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 0;
    drive(0, 1, 1, 32'h10, 0);
    drive(1, 1, 1, 32'h4, 0);
    for (int i = 0; i < 4; i++) begin
      v = (i % 2 == 0) ? tbl[1] : tbl[9];
      gq.push_back(v);
    end
    cprev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ev(0, 8, f, c, id);
      if (!f) chk("rr_timeout", 0, 1);
      else begin
        chk("rr_order", {31'b0, id}, i % 2);
        if (i > 0) chk("rr_spacing", c - cprev, 3);
        cprev = c;
      end
    end
    @(posedge CLK); #1;
    drive(0, 0, 1, 32'h10, 0);
    drive(1, 0, 1, 32'h4, 0);
    repeat (3) @(posedge CLK);
    #1;

    // Reset during the ACCESS cycle of a write: RAM must not be written.
    v = '{1'b0, 1'b0, 32'h0000_0020, 32'h12345678, 1'b0, 32'h0};
    drive(0, 1, 0, v.addr, v.wdata);
    gq.push_back(v);
    wait_ev(0, 8, f, c, id);
    if (!f) chk("rst_seq_gnt_timeout", 0, 1);
    #1;
    RESET = 1;
    drive(0, 0, 0, v.addr, v.wdata);
    #1;
    chk("rst_gates_wren", {31'b0, ram_wren}, 0);
    @(posedge CLK); #1;
    RESET = 0;
    v = '{1'b0, 1'b1, 32'h0000_0020, 32'h0, 1'b0, 32'hCAFEF00D};
    do_cmd(v);

    // m0 raises req during m1's ACCESS; it must wait for the IDLE after m1's RESP.
    @(posedge CLK); #1;
    drive(1, 1, 1, 32'hFFC, 0);
    gq.push_back(tbl[5]);
    wait_ev(0, 8, f, c, id);
    if (!f) chk("hold_gnt1_timeout", 0, 1);
    else    chk("hold_first_id", {31'b0, id}, 1);
    cprev = c;
    #1;
    drive(0, 1, 1, 32'h10, 0);
    gq.push_back(tbl[1]);
    @(posedge CLK); #1;
    drive(1, 0, 1, 32'hFFC, 0);
    wait_ev(0, 8, f, c, id);
    if (!f) chk("hold_gnt2_timeout", 0, 1);
    else begin
      chk("hold_second_id", {31'b0, id}, 0);
      chk("hold_wait", c - cprev, 3);
    end
    @(posedge CLK); #1;
    drive(0, 0, 1, 32'h10, 0);
    repeat (4) @(posedge CLK);

    @(negedge CLK);
    chk("gq_drained", gq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
